// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multi-cycle restoring signed divider, 16-bit dividend by 8-bit divisor
//
// Ports:
//   Clock_20M  in   system clock
//   Ex_Rst_n   in   asynchronous active-low reset, release synchronized internally
//   In_Valid   in   operand valid
//   In_Ready   out  idle and able to accept operands
//   Dividend   in   16-bit signed dividend
//   Divisor    in   8-bit signed divisor
//   Out_Valid  out  result valid, held until Out_Ready
//   Out_Ready  in   consumer accepts result
//   Quotient   out  16-bit signed quotient (truncated toward zero)
//   Remainder  out  8-bit signed remainder (sign of dividend)
//   Div_Zero   out  divisor was zero
//   Overflow   out  -32768 / -1, quotient saturated to 16'h7FFF

module seq_signed_divider (
  input  logic        Clock_20M,
  input  logic        Ex_Rst_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [15:0] Dividend,
  input  logic [7:0]  Divisor,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Quotient,
  output logic [7:0]  Remainder,
  output logic        Div_Zero,
  output logic        Overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXUP, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] dvd_in_q, dvd_in_d;
  logic [7:0]  dvs_in_q, dvs_in_d;
  logic        sign_quo_q, sign_quo_d;
  logic        sign_rem_q, sign_rem_d;
  logic [15:0] mag_dvd_q, mag_dvd_d;
  logic [8:0]  mag_dvs_q, mag_dvs_d;
  logic [8:0]  prem_q, prem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        overflow_q, overflow_d;

  logic [8:0]  dvs_sext;
  logic [8:0]  shifted;
  logic [9:0]  trial;
  logic        unused_prem_msb;

  // The partial remainder never exceeds 127 between iterations, so its top bit
  // is always zero and only the low 8 bits feed the shift.
  assign unused_prem_msb = &{1'b0, prem_q[8]};

  assign dvs_sext = {dvs_in_q[7], dvs_in_q};
  assign shifted  = {prem_q[7:0], mag_dvd_q[15]};
  assign trial    = {1'b0, shifted} - {1'b0, mag_dvs_q};

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], 1'b1};
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dvd_in_d    = dvd_in_q;
    dvs_in_d    = dvs_in_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    mag_dvd_d   = mag_dvd_q;
    mag_dvs_d   = mag_dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    // Hold everything idle until the reset release has cleared the synchronizer.
    if (!sync_q[1]) begin
      state_d     = IDLE;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_d = 1'b1;
          if (In_Valid && in_ready_q) begin
            dvd_in_d   = Dividend;
            dvs_in_d   = Divisor;
            in_ready_d = 1'b0;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          sign_quo_d = dvd_in_q[15] ^ dvs_in_q[7];
          sign_rem_d = dvd_in_q[15];
          mag_dvd_d  = dvd_in_q[15] ? (~dvd_in_q + 16'd1) : dvd_in_q;
          mag_dvs_d  = dvs_sext[8] ? (~dvs_sext + 9'd1) : dvs_sext;
          prem_d     = 9'd0;
          cnt_d      = 5'd0;
          state_d    = ITER;
        end
        ITER: begin
          // Dividend magnitude register doubles as the quotient shift register.
          mag_dvd_d = {mag_dvd_q[14:0], ~trial[9]};
          prem_d    = trial[9] ? shifted : trial[8:0];
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = FIXUP;
          end
        end
        FIXUP: begin
          if (dvs_in_q == 8'h00) begin
            quotient_d  = 16'h0000;
            remainder_d = 8'h00;
            div_zero_d  = 1'b1;
            overflow_d  = 1'b0;
          end else if (dvd_in_q == 16'h8000 && dvs_in_q == 8'hFF) begin
            quotient_d  = 16'h7FFF;
            remainder_d = 8'h00;
            div_zero_d  = 1'b0;
            overflow_d  = 1'b1;
          end else begin
            quotient_d  = sign_quo_q ? (~mag_dvd_q + 16'd1) : mag_dvd_q;
            remainder_d = sign_rem_q ? (~prem_q[7:0] + 8'd1) : prem_q[7:0];
            div_zero_d  = 1'b0;
            overflow_d  = 1'b0;
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (Out_Ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
    if (!Ex_Rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b00;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dvd_in_q    <= 16'h0000;
      dvs_in_q    <= 8'h00;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      mag_dvd_q   <= 16'h0000;
      mag_dvs_q   <= 9'h000;
      prem_q      <= 9'h000;
      cnt_q       <= 5'd0;
      quotient_q  <= 16'h0000;
      remainder_q <= 8'h00;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dvd_in_q    <= dvd_in_d;
      dvs_in_q    <= dvs_in_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      mag_dvd_q   <= mag_dvd_d;
      mag_dvs_q   <= mag_dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign Div_Zero  = div_zero_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - self-checking bench for seq_signed_divider

module tb_seq_signed_divider;

  logic        Clock_20M = 1'b0;
  logic        Ex_Rst_n  = 1'b0;
  logic        In_Valid  = 1'b0;
  logic        In_Ready;
  logic [15:0] Dividend  = 16'h0000;
  logic [7:0]  Divisor   = 8'h00;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        Div_Zero;
  logic        Overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    bit          dz;
    bit          ov;
    int          acc;
  } exp_t;

  exp_t eq[$];

  seq_signed_divider dut (
    .Clock_20M (Clock_20M),
    .Ex_Rst_n  (Ex_Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Div_Zero  (Div_Zero),
    .Overflow  (Overflow)
  );

  always #25 Clock_20M = ~Clock_20M;

  always @(posedge Clock_20M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Truncating integer division of the language is exactly the required rounding.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.acc = 0;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 0) begin
      e.q = 16'h0000; e.r = 8'h00; e.dz = 1'b1;
    end else if (a == -32768 && b == -1) begin
      e.q = 16'h7FFF; e.r = 8'h00; e.ov = 1'b1;
    end else begin
      e.q = 16'(a / b);
      e.r = 8'(a % b);
    end
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  In_Ready,  0);
    chk({tag, "_out_valid"}, Out_Valid, 0);
    chk({tag, "_quotient"},  Quotient,  0);
    chk({tag, "_remainder"}, Remainder, 0);
    chk({tag, "_div_zero"},  Div_Zero,  0);
    chk({tag, "_overflow"},  Overflow,  0);
  endtask

  // Compare process: every cycle, outputs are checked against the model queue.
  initial begin
    exp_t e;
    bit   seen = 1'b0;
    forever begin
      @(negedge Clock_20M);
      if (!Ex_Rst_n) begin
        eq.delete();
        seen = 1'b0;
        chk_reset_vals("in_reset");
      end else begin
        if (eq.size() == 0) begin
          chk("idle_no_valid", Out_Valid, 0);
        end else begin
          chk("busy_in_ready", In_Ready, 0);
          if (Out_Valid) begin
            e = eq[0];
            chk("cmp_quotient",  Quotient,  e.q);
            chk("cmp_remainder", Remainder, e.r);
            chk("cmp_div_zero",  Div_Zero,  e.dz);
            chk("cmp_overflow",  Overflow,  e.ov);
            if (!seen) chk("cmp_latency", cyc - e.acc, 18);
            seen = 1'b1;
            if (Out_Ready) begin
              void'(eq.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (In_Valid && In_Ready) begin
          e = model(int'($signed(Dividend)), int'($signed(Divisor)));
          e.acc = cyc + 1;
          eq.push_back(e);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge Clock_20M);
      n++;
    end while (!In_Ready && n < 60);
    chk("in_ready_timeout", In_Ready, 1);
    @(posedge Clock_20M);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    do begin
      @(negedge Clock_20M);
      n++;
    end while (!Out_Valid && n < 60);
    chk("out_valid_timeout", Out_Valid, 1);
  endtask

  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                       input logic [15:0] eq_q, input logic [7:0] eq_r,
                       input bit e_dz, input bit e_ov, input int hold);
    Dividend = dvd;
    Divisor  = dvs;
    In_Valid = 1'b1;
    wait_accept();
    In_Valid  = 1'b0;
    Out_Ready = (hold == 0);
    wait_out_valid();
    chk("lit_quotient",  Quotient,  eq_q);
    chk("lit_remainder", Remainder, eq_r);
    chk("lit_div_zero",  Div_Zero,  e_dz);
    chk("lit_overflow",  Overflow,  e_ov);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge Clock_20M);
        #1;
        chk("hold_in_ready",  In_Ready,  0);
        chk("hold_out_valid", Out_Valid, 1);
        chk("hold_quotient",  Quotient,  eq_q);
      end
      Out_Ready = 1'b1;
    end
    @(posedge Clock_20M);
    #1;
    chk("accept_in_ready",  In_Ready,  1);
    chk("accept_out_valid", Out_Valid, 0);
  endtask

  task automatic release_and_check();
    @(posedge Clock_20M);
    #10;
    Ex_Rst_n = 1'b1;
    @(posedge Clock_20M); #1; chk("rel_edge1_in_ready", In_Ready, 0);
    @(posedge Clock_20M); #1; chk("rel_edge2_in_ready", In_Ready, 0);
    @(posedge Clock_20M); #1; chk("rel_edge3_in_ready", In_Ready, 1);
  endtask

  int b_list[10] = '{1, -1, 2, -2, 7, -7, 127, -127, -128, 3};

  initial begin
    exp_t m;

    m = model(100, 7);
    chk("model_100_7_q", m.q, 16'd14);   chk("model_100_7_r", m.r, 8'd2);
    m = model(-100, 7);
    chk("model_m100_7_q", m.q, 16'hFFF2); chk("model_m100_7_r", m.r, 8'hFE);
    m = model(100, -7);
    chk("model_100_m7_q", m.q, 16'hFFF2); chk("model_100_m7_r", m.r, 8'h02);
    m = model(-32768, -1);
    chk("model_ovf_q", m.q, 16'h7FFF);    chk("model_ovf_flag", m.ov, 1);
    m = model(1234, 0);
    chk("model_dz_flag", m.dz, 1);        chk("model_dz_ovf", m.ov, 0);

    repeat (3) @(posedge Clock_20M);
    #1;
    chk_reset_vals("por");
    release_and_check();

    do_op(16'd100,  8'd7,   16'd14,   8'd2,   0, 0, 0);
    do_op(16'hFF9C, 8'd7,   16'hFFF2, 8'hFE,  0, 0, 0);
    do_op(16'd100,  8'hF9,  16'hFFF2, 8'h02,  0, 0, 0);
    do_op(16'hC000, 8'h80,  16'd128,  8'h00,  0, 0, 0);
    do_op(16'h8000, 8'h01,  16'h8000, 8'h00,  0, 0, 0);
    do_op(16'h7FFF, 8'h80,  16'hFF01, 8'h7F,  0, 0, 0);
    do_op(16'd1000, 8'd3,   16'd333,  8'd1,   0, 0, 5);

    // Back-to-back with In_Valid held high: overflow then divide-by-zero.
    Dividend = 16'h8000;
    Divisor  = 8'hFF;
    In_Valid = 1'b1;
    wait_accept();
    Dividend = 16'd1234;
    Divisor  = 8'h00;
    wait_out_valid();
    chk("b2b_ovf_q",    Quotient,  16'h7FFF);
    chk("b2b_ovf_r",    Remainder, 8'h00);
    chk("b2b_ovf_flag", Overflow,  1);
    wait_accept();
    In_Valid = 1'b0;
    wait_out_valid();
    chk("b2b_dz_q",    Quotient,  16'h0000);
    chk("b2b_dz_r",    Remainder, 8'h00);
    chk("b2b_dz_flag", Div_Zero,  1);
    chk("b2b_dz_ovf",  Overflow,  0);
    @(posedge Clock_20M);
    #1;

    // Reset in the middle of iteration.
    Dividend = 16'd5000;
    Divisor  = 8'd9;
    In_Valid = 1'b1;
    wait_accept();
    In_Valid = 1'b0;
    repeat (8) @(posedge Clock_20M);
    #5;
    Ex_Rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (2) @(negedge Clock_20M);
    release_and_check();
    repeat (25) @(posedge Clock_20M);
    #1;
    chk("post_rst_no_valid", Out_Valid, 0);

    // Multiplier round trip over every A for a spread of divisors.
    foreach (b_list[bi]) begin
      for (int a = -128; a <= 127; a++) begin
        do_op(16'(a * b_list[bi]), 8'(b_list[bi]), 16'(a), 8'h00, 0, 0, 0);
      end
    end

    // Random operands, checked by the model alone.
    for (int i = 0; i < 150; i++) begin
      Dividend = 16'($urandom);
      Divisor  = (i % 25 == 0) ? 8'h00 : 8'($urandom);
      In_Valid = 1'b1;
      wait_accept();
      In_Valid = 1'b0;
      wait_out_valid();
      @(posedge Clock_20M);
      #1;
    end

    repeat (3) @(posedge Clock_20M);
    chk("final_queue_empty", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
